// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

   localparam int FETCH_XLEN = 32;
   localparam logic [FETCH_XLEN-1:0] BUBBLE_INSTR  = 32'h0;
   localparam logic [FETCH_XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

   typedef struct packed {
      logic [FETCH_XLEN-1:0] instr;
      logic [FETCH_XLEN-1:0] pc;
      logic                  pred_taken;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry fetch queue storage; occupancy tracked by count, clear empties it.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   input  logic         clear,
   output fetch_entry_t head,
   output logic [CW-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t    mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_entry;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch PC generation, credit-gated imem issue and decoupled decode queue.
// Optional branch-prediction steering is enabled by defining FETCH_PRED_EN.
module fetch_queue_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            pred_taken,
   input  logic [XLEN-1:0] pred_target,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            dec_valid,
   input  logic            dec_ready,
   output logic [XLEN-1:0] dec_instr,
   output logic [XLEN-1:0] dec_pc,
   output logic [XLEN-1:0] dec_pc_plus4,
   output logic            dec_pred_taken
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = CW + 1;

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_next;
   logic [XLEN-1:0] inflight_pc;
   logic [XLEN-1:0] pred_pc;
   logic            inflight_valid;
   logic            inflight_pred;
   logic            pred_use;
   logic            issue;
   logic            dec_pop;
   logic [CW-1:0]   count;
   fetch_entry_t    head;
   fetch_entry_t    push_entry;

`ifdef FETCH_PRED_EN
   assign pred_use = pred_taken;
   assign pred_pc  = pred_target & PC_ALIGN_MASK;
`else
   logic pred_unused;
   assign pred_use    = 1'b0;
   assign pred_pc     = '0;
   assign pred_unused = ^{pred_taken, pred_target};
`endif

   assign dec_valid = (count != '0);
   assign dec_pop   = dec_valid && dec_ready;

   // Credit check: queued + in-flight entries, less the one leaving, must leave room.
   assign issue = rst_n && !redirect_valid &&
                  ((OW'(count) + OW'(inflight_valid)) < (OW'(DEPTH) + OW'(dec_pop)));

   always_comb begin
      pc_next = pc;
      if (redirect_valid)        pc_next = redirect_pc & PC_ALIGN_MASK;
      else if (issue && pred_use) pc_next = pred_pc;
      else if (issue)            pc_next = pc + XLEN'(4);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc             <= RESET_PC & PC_ALIGN_MASK;
         inflight_valid <= 1'b0;
      end else begin
         pc             <= pc_next;
         inflight_valid <= issue;
      end
   end

   always_ff @(posedge clk) begin
      if (issue) begin
         inflight_pc   <= pc;
         inflight_pred <= pred_use;
      end
   end

   // A redirect kills the response of the request still in flight.
   assign push_entry = '{instr: imem_rdata, pc: inflight_pc, pred_taken: inflight_pred};

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (inflight_valid && !redirect_valid),
      .push_entry (push_entry),
      .pop        (dec_pop),
      .clear      (redirect_valid),
      .head       (head),
      .count      (count)
   );

   assign imem_req       = issue;
   assign imem_addr      = pc;
   assign dec_instr      = dec_valid ? head.instr : BUBBLE_INSTR;
   assign dec_pc         = dec_valid ? head.pc : '0;
   assign dec_pc_plus4   = dec_valid ? head.pc + XLEN'(4) : '0;
   assign dec_pred_taken = dec_valid && head.pred_taken;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: vector table, directed corners, random vs queue model.
module tb_fetch_queue_unit;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_PRED_EN
   localparam bit PRED_EN = 1'b1;
`else
   localparam bit PRED_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic        pred_taken = 1'b0;
   logic [31:0] pred_target = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        dec_valid;
   logic        dec_ready = 1'b0;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic [31:0] dec_pc_plus4;
   logic        dec_pred_taken;

   int total = 0;
   int bad = 0;

   fetch_queue_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_instr      (dec_instr),
      .dec_pc         (dec_pc),
      .dec_pc_plus4   (dec_pc_plus4),
      .dec_pred_taken (dec_pred_taken)
   );

   always #5 clk = ~clk;

   // Instruction memory contents: a fixed, address-dependent pattern.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chkb(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   // Reference model: queue of decoded entries plus one outstanding request.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        pred;
   } ent_t;

   ent_t        q[$];
   bit          inf = 1'b0;
   logic [31:0] inf_pc = 32'h0;
   bit          inf_pred = 1'b0;
   logic [31:0] mpc = 32'h0;

   function automatic bit model_issue();
      bit pop;
      int occ;
      pop = (q.size() > 0) && dec_ready;
      occ = q.size() + int'(inf) - int'(pop);
      return !redirect_valid && (occ < DEPTH);
   endfunction

   task automatic model_check();
      ent_t h;
      bit   mv;
      mv = q.size() > 0;
      h  = mv ? q[0] : '0;
      chkb("req", imem_req, model_issue());
      chk("addr", imem_addr, mpc);
      chkb("dec_valid", dec_valid, mv);
      chk("dec_pc", dec_pc, h.pc);
      chk("dec_instr", dec_instr, h.instr);
      chk("dec_pc_plus4", dec_pc_plus4, mv ? h.pc + 32'd4 : 32'h0);
      chkb("dec_pred_taken", dec_pred_taken, h.pred);
   endtask

   task automatic model_update();
      bit iss;
      bit pt;
      iss = model_issue();
      pt  = PRED_EN && pred_taken;
      if ((q.size() > 0) && dec_ready) void'(q.pop_front());
      if (redirect_valid) begin
         q.delete();
         inf = 1'b0;
         mpc = redirect_pc & ~32'h3;
      end else begin
         if (inf) q.push_back('{mem(inf_pc), inf_pc, inf_pred});
         if (iss) begin
            inf_pc   = mpc;
            inf_pred = pt;
            mpc      = pt ? (pred_target & ~32'h3) : mpc + 32'd4;
         end
         inf = iss;
      end
   endtask

   task automatic drive(input bit rdy, input bit rv, input logic [31:0] rpc,
                        input bit pt, input logic [31:0] tgt);
      dec_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      pred_taken     = pt;
      pred_target    = tgt;
   endtask

   task automatic sample();
      @(negedge clk);
      model_check();
   endtask

   task automatic advance();
      bit          rq;
      logic [31:0] ra;
      rq = imem_req;
      ra = imem_addr;
      @(posedge clk);
      model_update();
      #1;
      imem_rdata = rq ? mem(ra) : $urandom;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chkb("rst_req", imem_req, 1'b0);
      chkb("rst_dec_valid", dec_valid, 1'b0);
      chk("rst_dec_pc", dec_pc, 32'h0);
      chk("rst_dec_instr", dec_instr, 32'h0);
      chk("rst_dec_pc_plus4", dec_pc_plus4, 32'h0);
      chkb("rst_dec_pred", dec_pred_taken, 1'b0);
      chk("rst_addr", imem_addr, RESET_PC);
      q.delete();
      inf = 1'b0;
      mpc = RESET_PC;
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   typedef struct {
      bit          rdy;
      bit          rv;
      logic [31:0] rpc;
      bit          req;
      logic [31:0] addr;
      bit          dv;
      logic [31:0] pc;
   } vec_t;

   vec_t vt[9];

   initial begin
      int          nreq;
      logic [31:0] pops[$];

      vt[0] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0};
      vt[1] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b0, 32'h0};
      vt[2] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h0};
      vt[3] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h4};
      vt[4] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h8};
      vt[5] = '{1'b1, 1'b1, 32'h103, 1'b0, 32'h14,  1'b1, 32'hC};
      vt[6] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0};
      vt[7] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0};
      vt[8] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h100};

      #1;
      do_reset();

      // Walk from reset, then a misaligned redirect.
      for (int i = 0; i < 9; i++) begin
         drive(vt[i].rdy, vt[i].rv, vt[i].rpc, 1'b0, 32'h0);
         sample();
         chkb($sformatf("vec%0d_req", i), imem_req, vt[i].req);
         chk($sformatf("vec%0d_addr", i), imem_addr, vt[i].addr);
         chkb($sformatf("vec%0d_dv", i), dec_valid, vt[i].dv);
         chk($sformatf("vec%0d_pc", i), dec_pc, vt[i].pc);
         chk($sformatf("vec%0d_p4", i), dec_pc_plus4, vt[i].dv ? vt[i].pc + 32'd4 : 32'h0);
         chk($sformatf("vec%0d_instr", i), dec_instr, vt[i].dv ? mem(vt[i].pc) : 32'h0);
         advance();
      end

      // Decode stall: credits run out after DEPTH requests, then drain in order.
      do_reset();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      nreq = 0;
      for (int i = 0; i < 10; i++) begin
         sample();
         if (imem_req) nreq++;
         advance();
      end
      chk("stall_reqs", nreq, DEPTH);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      for (int i = 0; i < 8; i++) begin
         sample();
         if (dec_valid && dec_ready) pops.push_back(dec_pc);
         advance();
      end
      chk("drain_count", pops.size(), 8);
      for (int i = 0; i < 5 && i < pops.size(); i++)
         chk($sformatf("drain%0d", i), pops[i], 32'(i * 4));

      // Redirect with 3 queued and 1 in flight.
      do_reset();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         sample();
         advance();
      end
      drive(1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
      sample();
      advance();
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      sample();
      chk("redir_addr", imem_addr, 32'h100);
      chkb("redir_empty1", dec_valid, 1'b0);
      advance();
      sample();
      chkb("redir_empty2", dec_valid, 1'b0);
      advance();
      sample();
      chkb("redir_dv", dec_valid, 1'b1);
      chk("redir_pc", dec_pc, 32'h100);
      advance();

      // Prediction on PC 8, then redirect beating a prediction.
      do_reset();
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      for (int i = 0; i < 2; i++) begin
         sample();
         advance();
      end
      drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h40);
      sample();
      chk("pred_at_pc", imem_addr, 32'h8);
      advance();
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      sample();
      chk("pred_next_addr", imem_addr, PRED_EN ? 32'h40 : 32'hC);
      advance();
      sample();
      chk("pred_entry_pc", dec_pc, 32'h8);
      chkb("pred_entry_flag", dec_pred_taken, PRED_EN);
      advance();
      drive(1'b1, 1'b1, 32'h200, 1'b1, 32'h40);
      sample();
      advance();
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      sample();
      chk("redir_beats_pred", imem_addr, 32'h200);
      advance();

      // Reset mid-stream with 2 entries queued.
      do_reset();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         sample();
         advance();
      end
      sample();
      chkb("mid_dv_before", dec_valid, 1'b1);
      #2;
      do_reset();
      sample();
      chk("restart_addr", imem_addr, RESET_PC);
      chkb("restart_req", imem_req, 1'b1);
      advance();

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom,
               $urandom_range(0, 4) == 0, $urandom);
         sample();
         advance();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
